iir_biquad_cascade: RTL and testbench

Parametrised cascade of Direct-Form-I biquad IIR sections for the audio equaliser path. One shared signed multiplier and accumulator are time-multiplexed over all sections and taps. The sample rate is set by a valid strobe, so the block runs from one system clock. Coefficients are loadable at run time through a write port. Outputs saturate instead of wrapping.

---
 rtl/iir_biquad_cascade.sv | 215 +++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - DF-I biquad cascade sharing one multiplier/accumulator
// Each section takes 5 MAC cycles plus 1 write-back cycle; the output saturates instead of wrapping.
module iir_biquad_cascade #(
  parameter int DW       = 24,
  parameter int CW       = 17,
  parameter int FRAC     = 15,
  parameter int SECTIONS = 4,
  parameter int CAW      = 6
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din,
  output logic                 out_valid,
  output logic signed [DW-1:0] dout,
  output logic                 busy,
  output logic                 overrun,
  output logic                 sat,
  input  logic                 coef_we,
  input  logic [CAW-1:0]       coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 coef_err,
  input  logic                 state_clr
);
  localparam int NC  = 5 * SECTIONS;
  localparam int AW  = DW + CW + 3;
  localparam int SW  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int CIW = $clog2(NC);
  localparam logic [CAW:0]         NC_W  = (CAW+1)'(NC);
  localparam logic [SW-1:0]        LAST  = SW'(SECTIONS - 1);
  localparam logic signed [CW-1:0] UNITY = CW'(2 ** FRAC);

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sec_q, sec_d;
  logic [2:0]            tap_q, tap_d;
  logic signed [DW-1:0]  x_q, x_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [CW-1:0]  coef_q [NC];
  logic signed [CW-1:0]  coef_d [NC];
  logic signed [DW-1:0]  x1_q [SECTIONS];
  logic signed [DW-1:0]  x1_d [SECTIONS];
  logic signed [DW-1:0]  x2_q [SECTIONS];
  logic signed [DW-1:0]  x2_d [SECTIONS];
  logic signed [DW-1:0]  y1_q [SECTIONS];
  logic signed [DW-1:0]  y1_d [SECTIONS];
  logic signed [DW-1:0]  y2_q [SECTIONS];
  logic signed [DW-1:0]  y2_d [SECTIONS];
  logic signed [DW-1:0]  dout_q, dout_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  sat_q, sat_d;
  logic                  coef_err_q, coef_err_d;

  logic [CIW-1:0]        coef_idx;
  logic signed [CW-1:0]  coef_sel;
  logic signed [DW-1:0]  opnd;
  logic signed [AW-1:0]  prod;
  logic signed [AW-1:0]  y_full;
  logic [AW-DW:0]        y_hi;
  logic                  ovf;
  logic signed [DW-1:0]  y_sat;

  always_comb begin
    coef_idx = CIW'(5 * int'(sec_q) + int'(tap_q));
    coef_sel = coef_q[coef_idx];
    case (tap_q)
      3'd0:    opnd = x_q;
      3'd1:    opnd = x1_q[sec_q];
      3'd2:    opnd = x2_q[sec_q];
      3'd3:    opnd = y1_q[sec_q];
      default: opnd = y2_q[sec_q];
    endcase
    prod   = AW'(coef_sel) * AW'(opnd);
    y_full = acc_q >>> FRAC;
    // Not clipping only when every bit above the DW-bit result is a copy of its sign.
    y_hi   = y_full[AW-1:DW-1];
    ovf    = !((&y_hi) || !(|y_hi));
    if (!ovf)
      y_sat = y_full[DW-1:0];
    else if (y_full[AW-1])
      y_sat = {1'b1, {(DW-1){1'b0}}};
    else
      y_sat = {1'b0, {(DW-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    tap_d       = tap_q;
    x_d         = x_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = in_valid && (state_q != IDLE);
    sat_d       = sat_q;
    coef_err_d  = 1'b0;

    if (coef_we) begin
      if (state_q == IDLE && {1'b0, coef_addr} < NC_W)
        coef_d[CIW'(coef_addr)] = coef_wdata;
      else
        coef_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (state_clr) begin
          for (int i = 0; i < SECTIONS; i++) begin
            x1_d[i] = '0;
            x2_d[i] = '0;
            y1_d[i] = '0;
            y2_d[i] = '0;
          end
          sat_d = 1'b0;
        end
        if (in_valid) begin
          x_d     = din;
          sec_d   = '0;
          tap_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        if (tap_q == 3'd0)
          acc_d = prod;
        else if (tap_q >= 3'd3)
          acc_d = acc_q - prod;
        else
          acc_d = acc_q + prod;
        if (tap_q == 3'd4)
          state_d = WB;
        else
          tap_d = tap_q + 3'd1;
      end
      WB: begin
        x2_d[sec_q] = x1_q[sec_q];
        x1_d[sec_q] = x_q;
        y2_d[sec_q] = y1_q[sec_q];
        y1_d[sec_q] = y_sat;
        if (ovf)
          sat_d = 1'b1;
        x_d   = y_sat;
        tap_d = '0;
        if (sec_q == LAST) begin
          dout_d      = y_sat;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          sec_d   = sec_q + SW'(1);
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sec_q       <= '0;
      tap_q       <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      for (int i = 0; i < NC; i++)
        coef_q[i] <= (i % 5 == 0) ? UNITY : '0;
      for (int i = 0; i < SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      sat_q       <= 1'b0;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      tap_q       <= tap_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      sat_q       <= sat_d;
      coef_err_q  <= coef_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign sat       = sat_q;
  assign coef_err  = coef_err_q;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - self-checking bench for iir_biquad_cascade
module tb_iir_biquad_cascade;
  localparam int DW = 24, CW = 17, FRAC = 15, SECTIONS = 4, CAW = 6;
  localparam int LAT = 6 * SECTIONS;
  localparam int NC  = 5 * SECTIONS;
  localparam longint YMAX = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint YMIN = -(64'sd1 <<< (DW - 1));

  logic                 clk_sys = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 out_valid;
  logic signed [DW-1:0] dout;
  logic                 busy, overrun, sat, coef_err;
  logic                 coef_we = 1'b0;
  logic [CAW-1:0]       coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic                 state_clr = 1'b0;

  iir_biquad_cascade #(.DW(DW), .CW(CW), .FRAC(FRAC), .SECTIONS(SECTIONS), .CAW(CAW)) dut (
    .clk_sys(clk_sys), .rst(rst), .in_valid(in_valid), .din(din),
    .out_valid(out_valid), .dout(dout), .busy(busy), .overrun(overrun), .sat(sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .state_clr(state_clr)
  );

  always #5 clk_sys = ~clk_sys;

  int pos_cyc = 0;
  always @(posedge clk_sys) pos_cyc <= pos_cyc + 1;

  typedef struct {
    int grp;
    int din;
    int exp;
    bit exp_sat;
    bit use_model;
  } vec_t;
  vec_t vt[$];

  int checks = 0;
  int errors = 0;
  longint exp_q[$];
  int     due_q[$];

  int     m_coef [NC];
  longint m_x1 [SECTIONS];
  longint m_x2 [SECTIONS];
  longint m_y1 [SECTIONS];
  longint m_y2 [SECTIONS];
  bit     m_sat;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_hist();
    for (int s = 0; s < SECTIONS; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
    m_sat = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_coef[i] = (i % 5 == 0) ? (1 << FRAC) : 0;
    model_clear_hist();
  endtask

  task automatic model_step(input longint xin, output longint yout);
    longint x, acc, y;
    x = xin;
    for (int s = 0; s < SECTIONS; s++) begin
      acc = m_coef[5*s] * x + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
          - m_coef[5*s+3] * m_y1[s] - m_coef[5*s+4] * m_y2[s];
      y = acc >>> FRAC;
      if (y > YMAX) begin y = YMAX; m_sat = 1; end
      else if (y < YMIN) begin y = YMIN; m_sat = 1; end
      m_x2[s] = m_x1[s]; m_x1[s] = x;
      m_y2[s] = m_y1[s]; m_y1[s] = y;
      x = y;
    end
    yout = x;
  endtask

  task automatic write_coef(input int s, input int k, input int val, input bit exp_err);
    coef_we    = 1'b1;
    coef_addr  = CAW'(5 * s + k);
    coef_wdata = CW'(val);
    @(posedge clk_sys); #1;
    coef_we = 1'b0;
    check("coef_err", coef_err, exp_err);
    if (!exp_err) m_coef[5*s+k] = val;
  endtask

  task automatic do_clear();
    state_clr = 1'b1;
    @(posedge clk_sys); #1;
    state_clr = 1'b0;
    model_clear_hist();
  endtask

  task automatic start_sample(input int d, input int e, input bit use_model);
    longint ym;
    model_step(longint'(d), ym);
    in_valid = 1'b1;
    din      = DW'(d);
    @(posedge clk_sys); #1;
    in_valid = 1'b0;
    exp_q.push_back(use_model ? ym : longint'(e));
    due_q.push_back(pos_cyc + LAT);
    check("busy_after_accept", busy, 1);
  endtask

  task automatic finish_sample();
    bit got = 0;
    for (int n = 0; n < LAT + 10 && !got; n++) begin
      @(negedge clk_sys);
      if (out_valid) got = 1;
    end
    check("out_valid_seen", got, 1);
    if (got && exp_q.size() > 0) begin
      check("dout", dout, exp_q.pop_front());
      check("latency", pos_cyc, due_q.pop_front());
      check("busy_at_out", busy, 0);
    end else begin
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic run_group(input int g, input int gap);
    foreach (vt[i]) begin
      if (vt[i].grp == g) begin
        start_sample(vt[i].din, vt[i].exp, vt[i].use_model);
        finish_sample();
        check("sat", sat, vt[i].use_model ? longint'(m_sat) : longint'(vt[i].exp_sat));
        repeat (gap) @(negedge clk_sys);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_coef_err"}, coef_err, 0);
  endtask

  initial begin
    int p;
    int seen;
    vt.push_back('{1, -654321, -654321, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0});
    vt.push_back('{1, 8388607, 8388607, 0, 0});
    vt.push_back('{1, -8388608, -8388608, 0, 0});
    vt.push_back('{2, 1000, 500, 0, 0});
    vt.push_back('{2, -3, -2, 0, 0});
    p = 1024;
    for (int i = 0; i < 12; i++) begin
      vt.push_back('{3, (i == 0) ? 1024 : 0, p, 0, 0});
      p = p / 2;
    end
    vt.push_back('{4, 8388607, 8388607, 1, 0});
    vt.push_back('{4, -8388608, -8388608, 1, 0});
    foreach (vt[i]) if (i < 0) vt.delete(i);
    vt.push_back('{5, 100000, 0, 0, 1});
    vt.push_back('{5, -50000, 0, 0, 1});
    vt.push_back('{5, 3000000, 0, 0, 1});
    vt.push_back('{5, -7000000, 0, 0, 1});
    vt.push_back('{5, 0, 0, 0, 1});
    vt.push_back('{5, 12345, 0, 0, 1});
    vt.push_back('{5, 8000000, 0, 0, 1});
    vt.push_back('{5, -8000000, 0, 0, 1});

    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check_idle_outputs("in_reset");
    rst = 1'b1;
    @(posedge clk_sys); #1;
    check_idle_outputs("after_reset");

    start_sample(123456, 123456, 0);
    check("dout_before_first", dout, 0);
    finish_sample();
    run_group(1, 0);

    write_coef(0, 0, 16384, 0);
    write_coef(1, 0, 32768, 0);
    do_clear();
    run_group(2, 0);

    write_coef(0, 0, 32768, 0);
    write_coef(0, 3, -16384, 0);
    do_clear();
    run_group(3, 6);
    start_sample(1024, 1024, 0);
    finish_sample();
    do_clear();
    start_sample(0, 0, 0);
    finish_sample();

    write_coef(0, 3, 0, 0);
    write_coef(0, 0, 65535, 0);
    do_clear();
    check("sat_before_clip", sat, 0);
    run_group(4, 0);
    do_clear();
    check("sat_cleared", sat, 0);

    write_coef(0, 0, 32768, 0);
    start_sample(5000, 5000, 0);
    repeat (4) @(posedge clk_sys);
    #1;
    in_valid = 1'b1;
    din      = DW'(999);
    @(posedge clk_sys); #1;
    in_valid = 1'b0;
    check("overrun_pulse", overrun, 1);
    write_coef(0, 0, 16384, 1);
    check("overrun_one_cycle", overrun, 0);
    finish_sample();
    start_sample(5000, 5000, 0);
    finish_sample();
    @(posedge clk_sys); #1;
    write_coef(SECTIONS, 0, 123, 1);
    @(posedge clk_sys); #1;
    check("coef_err_one_cycle", coef_err, 0);
    start_sample(6000, 6000, 0);
    finish_sample();

    write_coef(0, 0, 8192, 0);
    write_coef(0, 1, 8192, 0);
    write_coef(0, 2, 8192, 0);
    write_coef(0, 3, -8192, 0);
    write_coef(0, 4, 4096, 0);
    write_coef(1, 0, 40000, 0);
    write_coef(1, 1, -20000, 0);
    write_coef(1, 2, 10000, 0);
    write_coef(1, 4, -3000, 0);
    do_clear();
    run_group(5, 2);

    @(posedge clk_sys); #1;
    write_coef(0, 0, 16384, 0);
    start_sample(2000, 0, 0);
    repeat (9) @(posedge clk_sys);
    #1;
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    model_reset();
    #1;
    check("midreset_dout", dout, 0);
    check("midreset_busy", busy, 0);
    repeat (2) @(posedge clk_sys);
    #1;
    rst  = 1'b1;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_sys);
      if (out_valid) seen++;
    end
    check("midreset_no_out_valid", seen, 0);
    check("midreset_dout_held", dout, 0);
    start_sample(777, 777, 0);
    finish_sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
